// File: rtl/cpu_controller_if.sv
// cpu_controller_if -- bundle of the controller's start/instruction inputs
// and its datapath control outputs.
//
// Signals:
//   s, instr_in            start strobe and instruction word (into controller)
//   w                      ready: high while the controller idles in WAIT
//   vsel                   register-file write source select
//   loada/loadb/loadc      datapath register load strobes
//   loads, write           status load strobe, register-file write strobe
//   asel, bsel             ALU operand selects
//   readnum, writenum      register-file read/write indices
//   shift, ALUop           shifter and ALU controls
//   sximm8, sximm5         sign-extended immediates from the held instruction
//   illegal                one-cycle pulse on an unrecognised opcode
//
// Modports:
//   master  drives s/instr_in and observes the controls (datapath or bench)
//   slave   the controller itself
interface cpu_controller_if;
  logic        s;
  logic [15:0] instr_in;
  logic        w;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        write;
  logic        asel;
  logic        bsel;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        illegal;

  modport master (
    output s, instr_in,
    input  w, vsel, loada, loadb, loadc, loads, write, asel, bsel,
           readnum, writenum, shift, ALUop, sximm8, sximm5, illegal
  );

  modport slave (
    input  s, instr_in,
    output w, vsel, loada, loadb, loadc, loads, write, asel, bsel,
           readnum, writenum, shift, ALUop, sximm8, sximm5, illegal
  );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller -- multi-cycle instruction sequencer for a simple 16-bit
// datapath. An instruction is captured into IR when s is seen in WAIT, then
// walked through DECODE / GET_A / GET_B / ALU / WRITE_* before returning to
// WAIT. All control outputs are Moore: a function of the state and IR only.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (forces WAIT and IR=0 at once)
//   bus    cpu_controller_if.slave: s/instr_in in, datapath controls out
//
// Build option:
//   CPU_CTRL_HALT_EN  when defined, opcode 111 enters a HALT state that is
//                     left only by reset; otherwise opcode 111 is illegal.
module cpu_controller (
  input  logic             clk,
  input  logic             rst_n,
  cpu_controller_if.slave  bus
);

`ifdef CPU_CTRL_HALT_EN
  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_ALU       = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6,
    S_HALT      = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_ALU       = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  // IR fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  // Instruction classes
  logic is_mov_imm, is_mov_reg, is_mvn, is_cmp, is_two_operand;

  assign is_mov_imm     = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg     = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn         = (opcode == 3'b101) && (op == 2'b11);
  assign is_cmp         = (opcode == 3'b101) && (op == 2'b01);
  // ADD, CMP and AND read both Rn and Rm
  assign is_two_operand = (opcode == 3'b101) && (op != 2'b11);

  // Combinational outputs
  logic       w_o, loada_o, loadb_o, loadc_o, loads_o, write_o;
  logic       asel_o, bsel_o, illegal_o;
  logic [1:0] vsel_o, alu_op_o;
  logic [2:0] readnum_o, writenum_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    w_o        = 1'b0;
    vsel_o     = 2'b00;
    loada_o    = 1'b0;
    loadb_o    = 1'b0;
    loadc_o    = 1'b0;
    loads_o    = 1'b0;
    write_o    = 1'b0;
    asel_o     = 1'b0;
    bsel_o     = 1'b0;
    readnum_o  = 3'd0;
    writenum_o = 3'd0;
    alu_op_o   = 2'b00;
    illegal_o  = 1'b0;

    case (state_q)
      S_WAIT: begin
        w_o = 1'b1;
        if (bus.s) begin
          ir_d    = bus.instr_in;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_mov_imm) begin
          state_d = S_WRITE_IMM;
        end else if (is_mov_reg || is_mvn) begin
          // single-operand forms skip the Rn read
          state_d = S_GET_B;
        end else if (is_two_operand) begin
          state_d = S_GET_A;
`ifdef CPU_CTRL_HALT_EN
        end else if (opcode == 3'b111) begin
          state_d = S_HALT;
`endif
        end else begin
          illegal_o = 1'b1;
          state_d   = S_WAIT;
        end
      end

      S_GET_A: begin
        readnum_o = rn;
        loada_o   = 1'b1;
        state_d   = S_GET_B;
      end

      S_GET_B: begin
        readnum_o = rm;
        loadb_o   = 1'b1;
        state_d   = S_ALU;
      end

      S_ALU: begin
        loadc_o = 1'b1;
        if (is_mov_reg) begin
          // A forced to zero so the ALU passes the shifted B operand through
          asel_o   = 1'b1;
          alu_op_o = 2'b00;
        end else begin
          alu_op_o = op;
        end
        loads_o = is_cmp;
        state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      end

      S_WRITE_REG: begin
        vsel_o     = 2'b00;
        writenum_o = rd;
        write_o    = 1'b1;
        state_d    = S_WAIT;
      end

      S_WRITE_IMM: begin
        vsel_o     = 2'b10;
        writenum_o = rn;
        write_o    = 1'b1;
        state_d    = S_WAIT;
      end

`ifdef CPU_CTRL_HALT_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif

      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  assign bus.w        = w_o;
  assign bus.vsel     = vsel_o;
  assign bus.loada    = loada_o;
  assign bus.loadb    = loadb_o;
  assign bus.loadc    = loadc_o;
  assign bus.loads    = loads_o;
  assign bus.write    = write_o;
  assign bus.asel     = asel_o;
  assign bus.bsel     = bsel_o;
  assign bus.readnum  = readnum_o;
  assign bus.writenum = writenum_o;
  assign bus.ALUop    = alu_op_o;
  assign bus.illegal  = illegal_o;
  assign bus.shift    = sh;
  assign bus.sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
  assign bus.sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule
